// File: rtl/game_controller_if.sv
// Link between the game controller and the falling-letter column.
// The controller side (master) samples the column flags and drives the column's reset.
interface game_controller_if;
    logic correct;
    logic game_over;
    logic column_reset;

    modport master (
        input  correct,
        input  game_over,
        output column_reset
    );

    modport slave (
        output correct,
        output game_over,
        input  column_reset
    );
endinterface

// File: rtl/game_controller.sv
// Game-level controller for the falling-letter game: start button debounce,
// idle/play/over state machine, lives, BCD score and high score.
module game_controller #(
    parameter int LIVES           = 3,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start_button_n,
    game_controller_if.master  col,
    output logic               playing,
    output logic [1:0]         game_state,
    output logic [3:0]         lives,
    output logic [15:0]        score_bcd,
    output logic [15:0]        high_score_bcd
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t      state_q;
    logic        column_reset_q;
    logic        playing_q;
    logic [3:0]  lives_q;
    logic [15:0] score_q;
    logic [15:0] high_score_q;

    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             db_level_q, db_level_d;
    logic             start_press_q, start_press_d;
    logic             correct_prev_q, correct_prev_d;
    logic             game_over_prev_q, game_over_prev_d;
    logic             hit_q, hit_d;
    logic             loss_q, loss_d;

    // Saturating 4-digit BCD increment.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // The counter only runs while the synchronized button disagrees with the debounced level.
    always_comb begin
        sync_d        = {sync_q[0], start_button_n};
        db_cnt_d      = '0;
        db_level_d    = db_level_q;
        start_press_d = 1'b0;
        if (sync_q[1] != db_level_q) begin
            if (db_cnt_q == CNT_MAX) begin
                db_level_d    = sync_q[1];
                start_press_d = ~sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end

        correct_prev_d   = col.correct;
        game_over_prev_d = col.game_over;
        hit_d            = col.correct & ~correct_prev_q;
        // A bottom hit right after a match is the column parking itself, not a miss.
        loss_d           = col.game_over & ~game_over_prev_q & ~correct_prev_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q           <= 2'b11;
            db_cnt_q         <= '0;
            db_level_q       <= 1'b1;
            start_press_q    <= 1'b0;
            correct_prev_q   <= 1'b0;
            game_over_prev_q <= 1'b1;
            hit_q            <= 1'b0;
            loss_q           <= 1'b0;
        end else begin
            sync_q           <= sync_d;
            db_cnt_q         <= db_cnt_d;
            db_level_q       <= db_level_d;
            start_press_q    <= start_press_d;
            correct_prev_q   <= correct_prev_d;
            game_over_prev_q <= game_over_prev_d;
            hit_q            <= hit_d;
            loss_q           <= loss_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            column_reset_q <= 1'b1;
            playing_q      <= 1'b0;
            lives_q        <= LIVES_INIT;
            score_q        <= 16'h0000;
            high_score_q   <= 16'h0000;
        end else begin
            case (state_q)
                IDLE, OVER: begin
                    column_reset_q <= 1'b1;
                    playing_q      <= 1'b0;
                    if (start_press_q) begin
                        state_q        <= PLAY;
                        score_q        <= 16'h0000;
                        lives_q        <= LIVES_INIT;
                        column_reset_q <= 1'b0;
                        playing_q      <= 1'b1;
                    end
                end
                PLAY: begin
                    column_reset_q <= 1'b0;
                    playing_q      <= 1'b1;
                    if (hit_q) begin
                        score_q <= bcd_inc(score_q);
                    end else if (loss_q) begin
                        if (lives_q > 4'd1) begin
                            lives_q <= lives_q - 4'd1;
                        end else begin
                            lives_q        <= 4'd0;
                            state_q        <= OVER;
                            column_reset_q <= 1'b1;
                            playing_q      <= 1'b0;
                            if (score_q > high_score_q) begin
                                high_score_q <= score_q;
                            end
                        end
                    end
                end
                default: begin
                    state_q        <= IDLE;
                    column_reset_q <= 1'b1;
                    playing_q      <= 1'b0;
                end
            endcase
        end
    end

    assign col.column_reset  = column_reset_q;
    assign playing           = playing_q;
    assign game_state        = state_q;
    assign lives             = lives_q;
    assign score_bcd         = score_q;
    assign high_score_bcd    = high_score_q;

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Downstream stage of the falling-letter column: consumes its `correct` and `game_over` outputs and drives its `reset_signal`.
- Runs the game-level state machine (idle / playing / over), keeps lives and a 4-digit BCD score, and records the high score.
- Debounces the raw DE0 start pushbutton.
- Outputs feed the seven-segment / VGA display stages.

Parameters:
- LIVES, 3, lives at game start; legal range 1..15.
- DEBOUNCE_CYCLES, 500000, stable cycles required on the synchronized button (10 ms at 50 MHz); minimum 2.

Ports:
- clock  input  1  system clock, 50 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- start_button_n  input  1  raw DE0 pushbutton, active-low, asynchronous to clock.
- correct  input  1  column match flag; level, may stay high for more than one cycle.
- game_over  input  1  column bottom flag; level.
- column_reset  output  1  drives the column's reset_signal.
- playing  output  1  high in PLAY.
- game_state  output  2  0 = IDLE, 1 = PLAY, 2 = OVER.
- lives  output  4  remaining lives, binary.
- score_bcd  output  16  current score, 4 BCD digits, [15:12] most significant.
- high_score_bcd  output  16  best score since reset, same format.

Behaviour:
- Reset (async assert, sync-safe release):
  - game_state = IDLE, column_reset = 1, playing = 0.
  - lives = LIVES, score_bcd = 0, high_score_bcd = 0.
  - Synchronizer and debouncer are set to "released".
  - correct_d = 0, game_over_d = 1.
- Button path:
  - 2-FF synchronizer, then a counter.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples; the counter clears on any mismatch.
  - start_press is a 1-cycle pulse on the debounced released-to-pressed transition.
  - Holding the button produces exactly one pulse.
- Edge detect:
  - correct_d and game_over_d are registered copies of the inputs, updated every cycle in every state.
  - hit = correct & ~correct_d.
  - loss = game_over & ~game_over_d & ~correct_d. The column forces its bottom position on a match one cycle after correct, so a game_over rise that follows a correct cycle is not a loss.
- IDLE:
  - column_reset = 1; score holds its last value.
  - start_press -> PLAY.
- Entry to PLAY (from IDLE or OVER): score_bcd <= 0, lives <= LIVES, column_reset <= 0, all in the same cycle as the state change.
- PLAY:
  - column_reset = 0, playing = 1.
  - start_press is ignored.
  - hit: score += 1 in BCD with per-digit carry. Saturates at 9999 (no wrap).
  - loss with lives > 1: lives -= 1, stay in PLAY.
  - loss with lives == 1: lives <= 0, -> OVER.
  - hit and loss in the same cycle: hit wins; loss is discarded.
- Entry to OVER:
  - column_reset <= 1.
  - If score_bcd > high_score_bcd (4-digit BCD compare), high_score_bcd <= score_bcd on that same edge.
- OVER:
  - column_reset = 1; score, lives and high score hold.
  - start_press -> PLAY.
- Latency:
  - hit/loss are registered 1 cycle after the input edge.
  - Score, lives and state update on the next edge.
  - Total: outputs change 2 edges after the correct/game_over rising edge.
- Start of play: game_over is already high while the column sits at the bottom, so no false loss occurs. The column wraps to the top on its own.
- Code 3 on game_state is unreachable; if entered, go to IDLE next cycle.
- Reset mid-game: immediate return to reset values; the high score is also cleared.

Test Plan (DEBOUNCE_CYCLES=4, LIVES=3):
- Reset, hold start_button_n low for 3 cycles then release -> no start_press, state stays IDLE, column_reset = 1. Hold low for 6 cycles -> exactly one transition to PLAY; column_reset = 0, lives = 3, score = 0.
- In PLAY, correct high for 1 cycle, repeated 12 times -> score_bcd = 16'h0012, each update 2 edges after the rise. correct held high for 5 cycles -> score increments by 1 only.
- correct pulse, then game_over rising on the next cycle -> score +1, lives unchanged. Isolated game_over rise -> lives 3 -> 2.
- Three isolated losses -> lives = 0, state = OVER, column_reset = 1, high_score_bcd = score. Start press -> PLAY, score = 0, lives = 3, high score retained. Lower final score -> high score unchanged.
- Preload score via 9999 hits, then one more hit -> score stays 16'h9999.
- reset_n asserted mid-PLAY, asynchronously between clock edges -> all outputs return to reset values before the next clock edge.
